mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Reset is rst, synchronous, active-high; clock is clk; all state changes on posedge clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  EX/MR bundle valid this cycle.
REQ-005 mem_rd_in, mem_write_in  in  1 each  load / store request.
REQ-006 alu_res_in  in  16  effective address, or ALU result for non-memory ops.
REQ-007 rd_data_2_in  in  16  store data.
REQ-008 reg_write_in  in  1; wr_add_in  in  3; opcode_in  in  4  writeback control, passed through.
REQ-009 stall_out  out  1  upstream holds EX/MR bundle while high.
REQ-010 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  16; dmem_wdata  out  16  data-memory request.
REQ-011 dmem_ack  in  1; dmem_rdata  in  16  memory completion; rdata valid when ack=1.
REQ-012 wb_valid  out  1; wb_reg_write  out  1; wb_addr  out  3; wb_data  out  16; wb_opcode  out  4; wb_z_flag  out  1  MR/WB bundle.
REQ-013 mem_err  out  1  sticky error flag.

Function
REQ-014 FSM states are IDLE, ACCESS, ABORT; encoding is free.
REQ-015 In IDLE, a non-memory op (in_valid=1, mem_rd_in=0, mem_write_in=0) appears on the wb_* outputs the next cycle: wb_valid=1, wb_data=alu_res_in, wb_z_flag=0, no stall.
REQ-016 In IDLE, a memory op is accepted when in_valid=1 and exactly one of mem_rd_in or mem_write_in is set: stall_out=1 combinationally in the same cycle.
REQ-017 On acceptance, the unit captures address, wdata, we, reg_write, wr_add and opcode, then enters ACCESS.
REQ-018 In ACCESS, dmem_req=1 and dmem_addr, dmem_wdata, dmem_we are held stable from the captured values.
REQ-019 stall_out stays 1 throughout ACCESS, including the cycle in which dmem_ack=1.
REQ-020 ACCESS with dmem_ack=1 leads to IDLE with dmem_req=0 the next cycle.
REQ-021 On that next cycle, wb_valid=1; a load drives wb_data=dmem_rdata, wb_z_flag=(dmem_rdata==0), wb_reg_write=captured value.
REQ-022 On that next cycle, a store drives wb_reg_write=0, wb_data=captured address, wb_z_flag=0.
REQ-023 Minimum memory-op latency: acceptance at cycle N, dmem_req first high at N+1, ack at N+1 gives wb_valid at N+2.
REQ-024 stall_out is low in the cycle after ack, so the next bundle can be accepted then (back-to-back ops).
REQ-025 A 4-bit timeout counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
REQ-026 If the counter reaches 15 with no ack, the next state is ABORT.
REQ-027 In ABORT (one cycle): dmem_req=0, mem_err is set, and wb_valid=1 with wb_reg_write=0; the FSM then returns to IDLE.
REQ-028 dmem_ack arriving in the same cycle the counter hits 15 is a normal completion; ack takes priority.
REQ-029 in_valid with both mem_rd_in and mem_write_in set issues no memory access: mem_err is set, and the next cycle gives wb_valid=1, wb_reg_write=0, no stall.
REQ-030 dmem_ack while in IDLE is ignored.
REQ-031 In all cycles other than those of REQ-015/021/022/027/029, wb_valid=0.
REQ-032 mem_err clears only on rst.

Reset
REQ-033 While rst=1: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, stall_out=0.
REQ-034 While rst=1: wb_valid=0, wb_reg_write=0, wb_addr=0, wb_data=0, wb_z_flag=0, wb_opcode=4'b1111, mem_err=0, counter=0.
REQ-035 rst during ACCESS: dmem_req drops at the next edge, the captured op is discarded, and no wb_valid is produced for it.

Verification
REQ-036 ALU op (alu_res_in=16'h1234, wr_add_in=3, reg_write_in=1) -> next cycle wb_valid=1, wb_data=16'h1234, wb_addr=3, stall_out never high.
REQ-037 Load at addr 16'h0040 with ack after 3 wait cycles, rdata=16'h0000 -> dmem_req high 4 cycles; stall_out high 5 cycles; wb_data=0, wb_z_flag=1, wb_reg_write=1.
REQ-038 Store addr 16'h0010, data 16'hBEEF, ack on first req cycle -> dmem_we=1, dmem_wdata=16'hBEEF; wb_valid at N+2 with wb_reg_write=0; a second store accepted at N+2 and issues correctly.
REQ-039 Load with ack never asserted -> dmem_req high 16 cycles, then ABORT; mem_err=1, wb_reg_write=0, FSM back in IDLE; ack at cycle 16 instead gives normal completion, mem_err=0.
REQ-040 mem_rd_in=mem_write_in=1 -> no dmem_req, mem_err=1, wb_reg_write=0.
REQ-041 rst asserted in 2nd ACCESS cycle -> next cycle dmem_req=0, wb_valid=0, wb_opcode=4'b1111, stall_out=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage between EX and WB.
// ALU results pass straight through to the MR/WB bundle one cycle later.
// Loads and stores are captured, issued to data memory and held until ack.
// If no ack arrives within 16 access cycles, the op is aborted and the
// sticky error flag is raised.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_rd_in,
    input  logic        mem_write_in,
    input  logic [15:0] alu_res_in,
    input  logic [15:0] rd_data_2_in,
    input  logic        reg_write_in,
    input  logic [2:0]  wr_add_in,
    input  logic [3:0]  opcode_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_opcode,
    output logic        wb_z_flag,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        reg_write_q, reg_write_d;
    logic [2:0]  wr_add_q, wr_add_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [3:0]  timeout_q, timeout_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [2:0]  wb_addr_q, wb_addr_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [3:0]  wb_opcode_q, wb_opcode_d;
    logic        wb_z_q, wb_z_d;
    logic        mem_err_q, mem_err_d;
    logic        stall;

    logic is_mem_op;
    logic is_conflict;
    logic is_alu_op;

    assign is_mem_op   = in_valid & (mem_rd_in ^ mem_write_in);
    assign is_conflict = in_valid & mem_rd_in & mem_write_in;
    assign is_alu_op   = in_valid & ~mem_rd_in & ~mem_write_in;

    // Next-state, capture, timeout and writeback-bundle logic.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        reg_write_d    = reg_write_q;
        wr_add_d       = wr_add_q;
        opcode_d       = opcode_q;
        timeout_d      = timeout_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        wb_opcode_d    = wb_opcode_q;
        wb_z_d         = wb_z_q;
        mem_err_d      = mem_err_q;
        stall          = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    stall       = 1'b1;
                    addr_d      = alu_res_in;
                    wdata_d     = rd_data_2_in;
                    we_d        = mem_write_in;
                    reg_write_d = reg_write_in;
                    wr_add_d    = wr_add_in;
                    opcode_d    = opcode_in;
                    timeout_d   = 4'd0;
                    state_d     = ACCESS;
                end else if (is_conflict) begin
                    mem_err_d      = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_addr_d      = wr_add_in;
                    wb_data_d      = alu_res_in;
                    wb_opcode_d    = opcode_in;
                    wb_z_d         = 1'b0;
                end else if (is_alu_op) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = reg_write_in;
                    wb_addr_d      = wr_add_in;
                    wb_data_d      = alu_res_in;
                    wb_opcode_d    = opcode_in;
                    wb_z_d         = 1'b0;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_addr_d   = wr_add_q;
                    wb_opcode_d = opcode_q;
                    if (we_q) begin
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = addr_q;
                        wb_z_d         = 1'b0;
                    end else begin
                        wb_reg_write_d = reg_write_q;
                        wb_data_d      = dmem_rdata;
                        wb_z_d         = (dmem_rdata == 16'h0000);
                    end
                end else if (timeout_q == 4'd15) begin
                    state_d        = ABORT;
                    mem_err_d      = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_addr_d      = wr_add_q;
                    wb_data_d      = addr_q;
                    wb_opcode_d    = opcode_q;
                    wb_z_d         = 1'b0;
                end else begin
                    timeout_d = timeout_q + 4'd1;
                end
            end
            ABORT: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= 16'h0000;
            wdata_q        <= 16'h0000;
            we_q           <= 1'b0;
            reg_write_q    <= 1'b0;
            wr_add_q       <= 3'd0;
            opcode_q       <= 4'd0;
            timeout_q      <= 4'd0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_addr_q      <= 3'd0;
            wb_data_q      <= 16'h0000;
            wb_opcode_q    <= 4'b1111;
            wb_z_q         <= 1'b0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            reg_write_q    <= reg_write_d;
            wr_add_q       <= wr_add_d;
            opcode_q       <= opcode_d;
            timeout_q      <= timeout_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            wb_opcode_q    <= wb_opcode_d;
            wb_z_q         <= wb_z_d;
            mem_err_q      <= mem_err_d;
        end
    end

    // The request and its fields come straight from the captured registers.
    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = dmem_req & we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign stall_out    = stall & ~rst;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_addr      = wb_addr_q;
    assign wb_data      = wb_data_q;
    assign wb_opcode    = wb_opcode_q;
    assign wb_z_flag    = wb_z_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
// Inputs change 1ns after the rising edge, outputs are checked 2ns after it.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mem_rd_in;
    logic        mem_write_in;
    logic [15:0] alu_res_in;
    logic [15:0] rd_data_2_in;
    logic        reg_write_in;
    logic [2:0]  wr_add_in;
    logic [3:0]  opcode_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  wb_opcode;
    logic        wb_z_flag;
    logic        mem_err;

    int total = 0;
    int bad = 0;
    int reqCnt;
    int stallCnt;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .mem_rd_in    (mem_rd_in),
        .mem_write_in (mem_write_in),
        .alu_res_in   (alu_res_in),
        .rd_data_2_in (rd_data_2_in),
        .reg_write_in (reg_write_in),
        .wr_add_in    (wr_add_in),
        .opcode_in    (opcode_in),
        .stall_out    (stall_out),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_opcode    (wb_opcode),
        .wb_z_flag    (wb_z_flag),
        .mem_err      (mem_err)
    );

    // 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [15:0] alu,
                                 input logic [15:0] d2, input logic rw, input logic [2:0] wa,
                                 input logic [3:0] op);
        in_valid     = v;
        mem_rd_in    = rd;
        mem_write_in = wr;
        alu_res_in   = alu;
        rd_data_2_in = d2;
        reg_write_in = rw;
        wr_add_in    = wa;
        opcode_in    = op;
    endtask

    task automatic clearInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 4'd0);
    endtask

    // Runs an already-presented memory op to its writeback; ackAt is the
    // zero-based access cycle that sees ack (negative means never).
    task automatic waitWb(input int ackAt, input logic [15:0] rdata);
        stallCnt = stall_out ? 1 : 0;
        reqCnt   = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            clearInputs();
            dmem_ack   = (i == ackAt);
            dmem_rdata = rdata;
            settle();
            if (wb_valid) break;
            if (stall_out) stallCnt++;
            if (dmem_req) reqCnt++;
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0000;
        clearInputs();

        // Reset state.
        cyc();
        cyc();
        settle();
        checkOutput("rst_req", {15'd0, dmem_req}, 16'd0);
        checkOutput("rst_stall", {15'd0, stall_out}, 16'd0);
        checkOutput("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        checkOutput("rst_wb_opcode", {12'd0, wb_opcode}, 16'h000F);
        checkOutput("rst_wb_data", wb_data, 16'h0000);
        checkOutput("rst_mem_err", {15'd0, mem_err}, 16'd0);
        checkOutput("rst_addr", dmem_addr, 16'h0000);

        // ALU pass-through.
        cyc();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 3'd3, 4'd2);
        settle();
        checkOutput("alu_stall0", {15'd0, stall_out}, 16'd0);
        cyc();
        clearInputs();
        settle();
        checkOutput("alu_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("alu_wb_data", wb_data, 16'h1234);
        checkOutput("alu_wb_addr", {13'd0, wb_addr}, 16'd3);
        checkOutput("alu_wb_rw", {15'd0, wb_reg_write}, 16'd1);
        checkOutput("alu_wb_op", {12'd0, wb_opcode}, 16'd2);
        checkOutput("alu_stall1", {15'd0, stall_out}, 16'd0);
        cyc();
        settle();
        checkOutput("alu_wb_valid_drop", {15'd0, wb_valid}, 16'd0);

        // Load with three wait cycles, zero data.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3'd5, 4'd4);
        settle();
        checkOutput("ld_accept_stall", {15'd0, stall_out}, 16'd1);
        waitWb(3, 16'h0000);
        checkOutput("ld_req_cycles", reqCnt[15:0], 16'd4);
        checkOutput("ld_stall_cycles", stallCnt[15:0], 16'd5);
        checkOutput("ld_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("ld_wb_data", wb_data, 16'h0000);
        checkOutput("ld_wb_z", {15'd0, wb_z_flag}, 16'd1);
        checkOutput("ld_wb_rw", {15'd0, wb_reg_write}, 16'd1);
        checkOutput("ld_wb_addr", {13'd0, wb_addr}, 16'd5);
        checkOutput("ld_stall_after", {15'd0, stall_out}, 16'd0);
        checkOutput("ld_req_after", {15'd0, dmem_req}, 16'd0);

        // Store with immediate ack, then a back-to-back store.
        cyc();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 3'd1, 4'd6);
        settle();
        checkOutput("st_accept_stall", {15'd0, stall_out}, 16'd1);
        cyc();
        clearInputs();
        dmem_ack = 1'b1;
        settle();
        checkOutput("st_req", {15'd0, dmem_req}, 16'd1);
        checkOutput("st_we", {15'd0, dmem_we}, 16'd1);
        checkOutput("st_addr", dmem_addr, 16'h0010);
        checkOutput("st_wdata", dmem_wdata, 16'hBEEF);
        cyc();
        dmem_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, 3'd2, 4'd6);
        settle();
        checkOutput("st_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("st_wb_rw", {15'd0, wb_reg_write}, 16'd0);
        checkOutput("st_wb_data", wb_data, 16'h0010);
        checkOutput("st_wb_z", {15'd0, wb_z_flag}, 16'd0);
        checkOutput("st2_accept_stall", {15'd0, stall_out}, 16'd1);
        cyc();
        clearInputs();
        dmem_ack = 1'b1;
        settle();
        checkOutput("st2_req", {15'd0, dmem_req}, 16'd1);
        checkOutput("st2_addr", dmem_addr, 16'h0020);
        checkOutput("st2_wdata", dmem_wdata, 16'h1234);
        checkOutput("st2_we", {15'd0, dmem_we}, 16'd1);
        checkOutput("st2_wb_valid0", {15'd0, wb_valid}, 16'd0);
        cyc();
        dmem_ack = 1'b0;
        settle();
        checkOutput("st2_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("st2_wb_data", wb_data, 16'h0020);

        // Ack on the last allowed access cycle completes normally.
        cyc();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 3'd2, 4'd4);
        settle();
        waitWb(15, 16'h00A5);
        checkOutput("late_req_cycles", reqCnt[15:0], 16'd16);
        checkOutput("late_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("late_wb_data", wb_data, 16'h00A5);
        checkOutput("late_wb_z", {15'd0, wb_z_flag}, 16'd0);
        checkOutput("late_wb_rw", {15'd0, wb_reg_write}, 16'd1);
        checkOutput("late_mem_err", {15'd0, mem_err}, 16'd0);

        // No ack at all: abort after 16 request cycles.
        cyc();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0090, 16'h0000, 1'b1, 3'd6, 4'd4);
        settle();
        waitWb(-1, 16'h0000);
        checkOutput("abt_req_cycles", reqCnt[15:0], 16'd16);
        checkOutput("abt_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("abt_wb_rw", {15'd0, wb_reg_write}, 16'd0);
        checkOutput("abt_mem_err", {15'd0, mem_err}, 16'd1);
        checkOutput("abt_req", {15'd0, dmem_req}, 16'd0);
        cyc();
        settle();
        checkOutput("abt_wb_valid_drop", {15'd0, wb_valid}, 16'd0);
        checkOutput("abt_idle_stall", {15'd0, stall_out}, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b1, 3'd7, 4'd1);
        cyc();
        clearInputs();
        settle();
        checkOutput("abt_idle_alu", wb_data, 16'h7777);
        checkOutput("abt_err_sticky", {15'd0, mem_err}, 16'd1);

        // Clear the error, then a conflicting rd+wr request.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        checkOutput("cf_err_cleared", {15'd0, mem_err}, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0055, 16'h0000, 1'b1, 3'd4, 4'd7);
        settle();
        checkOutput("cf_stall", {15'd0, stall_out}, 16'd0);
        cyc();
        clearInputs();
        settle();
        checkOutput("cf_wb_valid", {15'd0, wb_valid}, 16'd1);
        checkOutput("cf_wb_rw", {15'd0, wb_reg_write}, 16'd0);
        checkOutput("cf_mem_err", {15'd0, mem_err}, 16'd1);
        checkOutput("cf_req", {15'd0, dmem_req}, 16'd0);

        // Stray ack in idle is ignored.
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hFFFF;
        cyc();
        dmem_ack = 1'b0;
        settle();
        checkOutput("idle_ack_wb", {15'd0, wb_valid}, 16'd0);
        checkOutput("idle_ack_req", {15'd0, dmem_req}, 16'd0);

        // Reset in the second access cycle discards the op.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h00C0, 16'h0000, 1'b1, 3'd3, 4'd4);
        cyc();
        clearInputs();
        settle();
        checkOutput("rsta_req1", {15'd0, dmem_req}, 16'd1);
        cyc();
        rst = 1'b1;
        settle();
        checkOutput("rsta_req2", {15'd0, dmem_req}, 16'd1);
        cyc();
        rst = 1'b0;
        settle();
        checkOutput("rsta_req", {15'd0, dmem_req}, 16'd0);
        checkOutput("rsta_wb_valid", {15'd0, wb_valid}, 16'd0);
        checkOutput("rsta_wb_opcode", {12'd0, wb_opcode}, 16'h000F);
        checkOutput("rsta_stall", {15'd0, stall_out}, 16'd0);
        cyc();
        settle();
        checkOutput("rsta_no_wb", {15'd0, wb_valid}, 16'd0);
        checkOutput("rsta_no_req", {15'd0, dmem_req}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
